// File: rtl/bus_pkg.sv
// Shared definitions for the request/ready memory bus: widths, transfer
// direction codes and the responder state encoding.
package bus_pkg;

   localparam int BUS_DATA_W = 32;
   localparam int BUS_ADDR_W = 32;

   localparam logic BUS_READ  = 1'b0;
   localparam logic BUS_WRITE = 1'b1;

   typedef enum logic [1:0] {
      BUS_IDLE   = 2'd0,
      BUS_WAIT   = 2'd1,
      BUS_ACCESS = 2'd2,
      BUS_ACK    = 2'd3
   } bus_state_t;

endpackage

// File: rtl/bus_ram_array.sv
// Single-port word RAM with a registered read port (one-cycle latency).
// Contents are never cleared; reset has no effect on the array.
module bus_ram_array
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clock,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_index,
   input  logic [BUS_DATA_W-1:0] i_wdata,
   output logic [BUS_DATA_W-1:0] o_rdata
);

   logic [BUS_DATA_W-1:0] mem [2**ADDR_WIDTH];

   // Reads and writes never target the same cycle, so read-old-data is fine.
   always_ff @(posedge i_clock) begin
      if (i_we) begin
         mem[i_index] <= i_wdata;
      end
      o_rdata <= mem[i_index];
   end

endmodule

// File: rtl/bus_ram_responder.sv
// RAM target for the request/ready bus with programmable wait states and
// optional out-of-range detection; ready is held until request drops.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// BUS_IDLE   | waiting for a request; captures address/rw/data/range flag
// BUS_WAIT   | wait-state countdown; request low here aborts the transfer
// BUS_ACCESS | one cycle: write commit or synchronous array read
// BUS_ACK    | ready (and error) presented while request stays high
module bus_ram_responder
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1,
   parameter bit RANGE_CHECK = 1'b1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_request,
   input  logic                  i_rw,
   input  logic [BUS_ADDR_W-1:0] i_address,
   input  logic [BUS_DATA_W-1:0] i_data,
   output logic [BUS_DATA_W-1:0] o_data,
   output logic                  o_ready,
   output logic                  o_error
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   bus_state_t            state;
   bus_state_t            state_nxt;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic                  rw_q;
   logic                  oor_q;
   logic [BUS_DATA_W-1:0] wdata_q;
   logic [BUS_DATA_W-1:0] rdata;
   logic                  oor_in;
   logic                  capture;
   logic                  ram_we;
   logic                  ready_nxt;
   logic [1:0]            unused_addr_lsb;

   assign unused_addr_lsb = i_address[1:0];
   assign oor_in = RANGE_CHECK && ((i_address >> (ADDR_WIDTH + 2)) != '0);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= BUS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BUS_IDLE: begin
            if (i_request) begin
               state_nxt = (WAIT_STATES == 0) ? BUS_ACCESS : BUS_WAIT;
            end
         end
         BUS_WAIT: begin
            if (!i_request) begin
               state_nxt = BUS_IDLE;
            end else if (wait_cnt == 4'd1) begin
               state_nxt = BUS_ACCESS;
            end
         end
         BUS_ACCESS: state_nxt = BUS_ACK;
         BUS_ACK: begin
            if (!i_request) begin
               state_nxt = BUS_IDLE;
            end
         end
         default: state_nxt = BUS_IDLE;
      endcase
   end

   // A reset landing on the ACCESS edge must not commit the pending write.
   always_comb begin
      capture   = (state == BUS_IDLE) && i_request;
      ram_we    = (state == BUS_ACCESS) && (rw_q == BUS_WRITE) && !oor_q && !i_reset;
      ready_nxt = (state == BUS_ACK) && i_request;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wait_cnt <= '0;
         idx_q    <= '0;
         rw_q     <= BUS_READ;
         oor_q    <= 1'b0;
         wdata_q  <= '0;
         o_ready  <= 1'b0;
         o_error  <= 1'b0;
         o_data   <= '0;
      end else begin
         if (capture) begin
            idx_q    <= i_address[ADDR_WIDTH+1:2];
            rw_q     <= i_rw;
            oor_q    <= oor_in;
            wdata_q  <= i_data;
            wait_cnt <= WAIT_INIT;
         end else if ((state == BUS_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         o_ready <= ready_nxt;
         o_error <= ready_nxt && oor_q;
         // Load read data once on entry to ready so it stays frozen while held.
         if (ready_nxt && !o_ready) begin
            o_data <= ((rw_q == BUS_READ) && !oor_q) ? rdata : '0;
         end else if (!ready_nxt) begin
            o_data <= '0;
         end
      end
   end

   bus_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .i_clock (i_clock),
      .i_we    (ram_we),
      .i_index (idx_q),
      .i_wdata (wdata_q),
      .o_rdata (rdata)
   );

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Responder end of the CPU request/ready memory bus: a word-wide synchronous RAM target with configurable wait states.
- The CPU (initiator) drives request, rw, address and write data, and samples ready and read data.
- The block sits behind the system address decoder and serves instruction fetches and data loads/stores.
- It has a held-ready handshake, so an initiator that drops request one cycle after seeing ready completes exactly one transfer.

Parameters:
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles between request capture and the array access (0..15).
- RANGE_CHECK, 1, when 1, accesses with i_address[31:ADDR_WIDTH+2] != 0 are out of range.

Ports:
- i_clock  in  1  clock; all logic on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_request  in  1  initiator request; held high until ready is seen.
- i_rw  in  1  0 = read, 1 = write; valid while i_request is high.
- i_address  in  32  byte address; bits [1:0] ignored (word access only).
- i_data  in  32  write data from the initiator.
- o_data  out  32  read data; valid while o_ready is high.
- o_ready  out  1  transfer complete.
- o_error  out  1  pulses with o_ready when the access was out of range.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: i_reset sampled high at a rising edge forces the reset state; there is no asynchronous path.
- Reset values: o_ready=0, o_error=0, o_data=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- Reset mid-operation: any transfer is abandoned and a pending write is not committed.
- State IDLE, o_ready=0:
  - On i_request=1, latch address word index, rw, write data and the range flag.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT, or to ACCESS if WAIT_STATES=0.
- State WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1.
  - If i_request is sampled 0 in WAIT, abort to IDLE: no write, no ready.
- State ACCESS (one cycle):
  - Write: commit the latched data to RAM unless out of range.
  - Read: the array performs a synchronous read of the latched index.
  - Next state is ACK.
- State ACK:
  - o_ready=1. o_data holds the read word, or 0 for a write or an out-of-range read.
  - o_error=1 for the whole ACK interval if out of range.
  - Hold ACK while i_request=1.
  - When i_request is sampled 0, deassert o_ready/o_error and return to IDLE on the next edge.
- Latency: request first sampled high at edge T gives o_ready high from edge T+2+WAIT_STATES.
  - WAIT_STATES=0: ready after 2 cycles.
  - WAIT_STATES=1: ready after 3 cycles.
- Back-to-back transfers: a new request is accepted in the first IDLE cycle. Minimum one request-low cycle between transfers, which matches initiator behaviour.
- o_data is registered and stable for the entire ACK interval.
- Inputs are ignored outside the IDLE capture: changes to i_address/i_rw/i_data after capture have no effect.
- Out-of-range accesses are always acknowledged so the initiator never hangs. Reads return 0; writes are dropped.
- Address wrap: with RANGE_CHECK=0 the upper bits are ignored and the address aliases modulo the capacity.
- i_request=1 while i_reset=1: the request is ignored. It is captured on the first edge after reset release if still high.

Decomposition:
- Shared package (bus_pkg):
  - state encodings: BUS_IDLE, BUS_WAIT, BUS_ACCESS, BUS_ACK;
  - BUS_READ=0 and BUS_WRITE=1 constants;
  - data and address width constants (32).
- Sub-module bus_ram_array: single-port synchronous RAM.
  - Ports: i_clock, i_we, i_index[ADDR_WIDTH-1:0], i_wdata, o_rdata.
  - Registered read, one-cycle latency.
  - Write-first is not required because there is no simultaneous read/write.
- The FSM, counter and output registers live in bus_ram_responder.

Test Plan:
- Write then read, WAIT_STATES=1:
  - Write 0xDEADBEEF to 0x0000_0010; drop request on ready.
  - Read 0x0000_0010 → ready 3 cycles after request; o_data=0xDEADBEEF; o_error=0.
- Ignored low bits: write 0x12345678 to 0x24, read 0x27 → o_data=0x12345678.
- Held request, WAIT_STATES=0: hold i_request high 5 cycles after ready.
  - o_ready stays 1 and o_data is stable.
  - After request drops, o_ready=0 next edge; a new request 1 cycle later is accepted.
- Out of range (ADDR_WIDTH=10, RANGE_CHECK=1):
  - Write 0xAAAA5555 to 0x0000_1000 → ready with o_error=1.
  - Read 0x0000_0000 afterwards still returns the prior value, not 0xAAAA5555.
  - Read 0x1000 → o_data=0, o_error=1.
- Abort in WAIT (WAIT_STATES=3): write 0xCAFEF00D to 0x40, drop request after 1 cycle.
  - No ready is produced.
  - Later read of 0x40 returns the old value.
- Reset mid-ACK: assert i_reset while o_ready=1 → next edge o_ready=0, o_data=0, state IDLE; the first request after release completes normally.
